// File: rtl/can_acf_pkg.sv
// Shared types and defaults for the CAN acceptance-filter controller.
package can_acf_pkg;

  localparam int DEF_NUM_AF = 4;
  localparam int DEF_ID_W   = 32;

  // Value the masked XOR must equal for a slot to match.
  localparam int COMPARE = 0;

  localparam logic CFG_SEL_MASK = 1'b0;
  localparam logic CFG_SEL_ID   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_WRITE = 2'd2
  } acf_state_e;

endpackage

// File: rtl/can_acf_match.sv
// Single-slot ID/mask compare: bits set in afmr must agree between id and afir.
module can_acf_match
  import can_acf_pkg::*;
#(
  parameter int ID_W = DEF_ID_W
) (
  input  logic [ID_W-1:0] id,
  input  logic [ID_W-1:0] afir,
  input  logic [ID_W-1:0] afmr,
  output logic            match
);

  assign match = (((id ^ afir) & afmr) == ID_W'(COMPARE));

endmodule

// File: rtl/can_acf_ctrl.sv
// CAN acceptance-filter controller: scans ID/mask slots one per cycle and
// forwards accepted IDs to the RX FIFO.
module can_acf_ctrl
  import can_acf_pkg::*;
#(
  parameter  int NUM_AF = DEF_NUM_AF,
  parameter  int ID_W   = DEF_ID_W,
  localparam int IDX_W  = (NUM_AF > 1) ? $clog2(NUM_AF) : 1
) (
  input  logic              i_sys_clk,
  input  logic              i_reset,
  input  logic [NUM_AF-1:0] i_uaf,
  input  logic              i_cfg_wr,
  input  logic              i_cfg_sel,
  input  logic [IDX_W-1:0]  i_cfg_idx,
  input  logic [ID_W-1:0]   i_cfg_data,
  output logic              o_cfg_err,
  input  logic              i_rx_valid,
  input  logic [ID_W-1:0]   i_rx_id,
  output logic              o_rx_ready,
  output logic              o_fifo_wr,
  output logic [ID_W-1:0]   o_fifo_id,
  output logic [IDX_W-1:0]  o_fifo_hit,
  output logic              o_fifo_all,
  input  logic              i_fifo_full,
  output logic              o_acfbsy,
  output logic              o_rej,
  output logic              o_ovf
);

  acf_state_e        state;
  logic [IDX_W-1:0]  idx;
  logic [ID_W-1:0]   afmr [NUM_AF];
  logic [ID_W-1:0]   afir [NUM_AF];
  logic [ID_W-1:0]   id_q;
  logic [NUM_AF-1:0] uaf_q;
  logic [IDX_W-1:0]  hit_q;
  logic              all_q;
  logic [ID_W-1:0]   last_id;
  logic [IDX_W-1:0]  last_hit;
  logic              last_all;
  logic              busy;
  logic              cfg_err;

  logic slot_match;
  logic slot_hit;
  logic last_slot;
  logic in_write;
  logic fifo_wr;

  can_acf_match #(.ID_W(ID_W)) u_match (
    .id    (id_q),
    .afir  (afir[idx]),
    .afmr  (afmr[idx]),
    .match (slot_match)
  );

  assign slot_hit  = slot_match && uaf_q[idx];
  assign last_slot = (idx == IDX_W'(NUM_AF - 1));

  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      state    <= ST_IDLE;
      idx      <= '0;
      afmr     <= '{default: '0};
      afir     <= '{default: '0};
      id_q     <= '0;
      uaf_q    <= '0;
      hit_q    <= '0;
      all_q    <= 1'b0;
      last_id  <= '0;
      last_hit <= '0;
      last_all <= 1'b0;
      busy     <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      // Writes are only safe while no message can be looking at the slot.
      if (i_cfg_wr) begin
        if (state == ST_IDLE && !i_uaf[i_cfg_idx]) begin
          if (i_cfg_sel == CFG_SEL_ID) afir[i_cfg_idx] <= i_cfg_data;
          else                         afmr[i_cfg_idx] <= i_cfg_data;
        end else begin
          cfg_err <= 1'b1;
        end
      end

      case (state)
        ST_IDLE: begin
          if (i_rx_valid) begin
            id_q  <= i_rx_id;
            uaf_q <= i_uaf;
            idx   <= '0;
            hit_q <= '0;
            busy  <= 1'b1;
            if (i_uaf == '0) begin
              all_q <= 1'b1;
              state <= ST_WRITE;
            end else begin
              all_q <= 1'b0;
              state <= ST_SCAN;
            end
          end
        end
        ST_SCAN: begin
          if (slot_hit) begin
            hit_q <= idx;
            state <= ST_WRITE;
          end else if (last_slot) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_WRITE: begin
          if (!i_fifo_full) begin
            last_id  <= id_q;
            last_hit <= hit_q;
            last_all <= all_q;
          end
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Pulses decode the registered state; reset masks them within the same cycle
  // so an aborted message never reaches the FIFO.
  assign in_write   = (state == ST_WRITE) && !i_reset;
  assign fifo_wr    = in_write && !i_fifo_full;
  assign o_fifo_wr  = fifo_wr;
  assign o_ovf      = in_write && i_fifo_full;
  assign o_rej      = (state == ST_SCAN) && last_slot && !slot_hit && !i_reset;
  assign o_rx_ready = (state == ST_IDLE) && !i_reset;
  assign o_acfbsy   = busy && !i_reset;
  assign o_cfg_err  = cfg_err && !i_reset;

  assign o_fifo_id  = i_reset ? '0   : (fifo_wr ? id_q  : last_id);
  assign o_fifo_hit = i_reset ? '0   : (fifo_wr ? hit_q : last_hit);
  assign o_fifo_all = i_reset ? 1'b0 : (fifo_wr ? all_q : last_all);

endmodule

// File: tb/tb_can_acf_ctrl.sv
// Self-checking bench for can_acf_ctrl against a message-level reference model.
module tb_can_acf_ctrl;

  localparam int NAF = 4;

  logic        i_sys_clk = 1'b0;
  logic        i_reset   = 1'b1;
  logic [3:0]  i_uaf     = '0;
  logic        i_cfg_wr  = 1'b0;
  logic        i_cfg_sel = 1'b0;
  logic [1:0]  i_cfg_idx = '0;
  logic [31:0] i_cfg_data = '0;
  logic        i_rx_valid = 1'b0;
  logic [31:0] i_rx_id   = '0;
  logic        i_fifo_full = 1'b0;
  logic        o_cfg_err, o_rx_ready, o_fifo_wr, o_fifo_all, o_acfbsy, o_rej, o_ovf;
  logic [31:0] o_fifo_id;
  logic [1:0]  o_fifo_hit;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_afmr [NAF];
  logic [31:0] m_afir [NAF];
  logic [31:0] m_last_id;
  logic [1:0]  m_last_hit;
  logic        m_last_all;

  can_acf_ctrl #(.NUM_AF(NAF), .ID_W(32)) dut (
    .i_sys_clk  (i_sys_clk),
    .i_reset    (i_reset),
    .i_uaf      (i_uaf),
    .i_cfg_wr   (i_cfg_wr),
    .i_cfg_sel  (i_cfg_sel),
    .i_cfg_idx  (i_cfg_idx),
    .i_cfg_data (i_cfg_data),
    .o_cfg_err  (o_cfg_err),
    .i_rx_valid (i_rx_valid),
    .i_rx_id    (i_rx_id),
    .o_rx_ready (o_rx_ready),
    .o_fifo_wr  (o_fifo_wr),
    .o_fifo_id  (o_fifo_id),
    .o_fifo_hit (o_fifo_hit),
    .o_fifo_all (o_fifo_all),
    .i_fifo_full(i_fifo_full),
    .o_acfbsy   (o_acfbsy),
    .o_rej      (o_rej),
    .o_ovf      (o_ovf)
  );

  always #5 i_sys_clk = ~i_sys_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge i_sys_clk);
    #1;
  endtask

  function automatic void model_reset();
    for (int k = 0; k < NAF; k++) begin
      m_afmr[k] = '0;
      m_afir[k] = '0;
    end
    m_last_id  = '0;
    m_last_hit = '0;
    m_last_all = 1'b0;
  endfunction

  function automatic void model_cfg(input logic sel, input logic [1:0] idx, input logic [31:0] data);
    if (sel) m_afir[idx] = data;
    else     m_afmr[idx] = data;
  endfunction

  // kind: 0 = accepted with no slot enabled, 1 = slot hit, 2 = rejected.
  // lat: cycle, counted from the accept cycle, in which the outcome shows.
  function automatic void predict(input logic [31:0] id, input logic [3:0] uaf,
                                  output int lat, output int kind, output int hit);
    lat = NAF; kind = 2; hit = 0;
    if (uaf == 4'b0000) begin
      lat = 1; kind = 0;
      return;
    end
    for (int k = NAF - 1; k >= 0; k--)
      if (uaf[k] && (((id ^ m_afir[k]) & m_afmr[k]) == 32'h0)) begin
        lat = k + 2; kind = 1; hit = k;
      end
  endfunction

  task automatic cfg_write(input logic sel, input logic [1:0] idx, input logic [31:0] data,
                           input logic [3:0] uaf);
    logic exp_err;
    exp_err    = uaf[idx];
    i_cfg_wr   = 1'b1;
    i_cfg_sel  = sel;
    i_cfg_idx  = idx;
    i_cfg_data = data;
    i_uaf      = uaf;
    step();
    i_cfg_wr   = 1'b0;
    i_cfg_data = $urandom;
    #1;
    n_cmp++;
    if (o_cfg_err !== exp_err) begin
      n_err++;
      $display("FAIL cfg_write_err: got %b expected %b (idx %0d uaf %b)", o_cfg_err, exp_err, idx, uaf);
    end
    if (!exp_err) model_cfg(sel, idx, data);
  endtask

  task automatic run_msg(input logic [31:0] id, input logic [3:0] uaf, input logic full,
                         input logic cw, input logic csel, input logic [1:0] cidx,
                         input logic [31:0] cdata);
    int lat, kind, hit;
    logic exp_err;
    exp_err = cw && uaf[cidx];
    if (cw && !exp_err) model_cfg(csel, cidx, cdata);
    predict(id, uaf, lat, kind, hit);
    i_rx_valid  = 1'b1;
    i_rx_id     = id;
    i_uaf       = uaf;
    i_fifo_full = full;
    i_cfg_wr    = cw;
    i_cfg_sel   = csel;
    i_cfg_idx   = cidx;
    i_cfg_data  = cdata;
    #1;
    n_cmp++;
    if (o_rx_ready !== 1'b1) begin
      n_err++;
      $display("FAIL accept_ready: got %b expected 1", o_rx_ready);
    end
    step();
    i_rx_valid = 1'b0;
    i_cfg_wr   = 1'b0;
    i_rx_id    = $urandom;
    for (int c = 1; c <= lat; c++) begin
      i_uaf = 4'($urandom);
      #1;
      if (c == 1) begin
        n_cmp++;
        if (o_cfg_err !== exp_err) begin
          n_err++;
          $display("FAIL cfg_err_at_accept: got %b expected %b", o_cfg_err, exp_err);
        end
      end
      if (c < lat) begin
        n_cmp++;
        if ({o_fifo_wr, o_rej, o_ovf, o_rx_ready, o_acfbsy} !== 5'b00001) begin
          n_err++;
          $display("FAIL busy_window: cycle %0d wr/rej/ovf/rdy/bsy got %b expected 00001",
                   c, {o_fifo_wr, o_rej, o_ovf, o_rx_ready, o_acfbsy});
        end
      end else if (kind == 2) begin
        n_cmp++;
        if ({o_fifo_wr, o_rej, o_ovf, o_acfbsy} !== 4'b0101) begin
          n_err++;
          $display("FAIL reject_pulse: cycle %0d wr/rej/ovf/bsy got %b expected 0101",
                   c, {o_fifo_wr, o_rej, o_ovf, o_acfbsy});
        end
      end else begin
        n_cmp++;
        if ({o_fifo_wr, o_rej, o_ovf, o_acfbsy} !== (full ? 4'b0011 : 4'b1001)) begin
          n_err++;
          $display("FAIL write_strobe: cycle %0d wr/rej/ovf/bsy got %b expected %b",
                   c, {o_fifo_wr, o_rej, o_ovf, o_acfbsy}, (full ? 4'b0011 : 4'b1001));
        end
        if (!full) begin
          n_cmp++;
          if ({o_fifo_id, o_fifo_hit, o_fifo_all} !== {id, 2'(hit), (kind == 0)}) begin
            n_err++;
            $display("FAIL fifo_data: got id %h hit %0d all %b expected id %h hit %0d all %b",
                     o_fifo_id, o_fifo_hit, o_fifo_all, id, hit, (kind == 0));
          end
          m_last_id  = id;
          m_last_hit = 2'(hit);
          m_last_all = (kind == 0);
        end
      end
      step();
    end
    #1;
    n_cmp++;
    if ({o_fifo_wr, o_rej, o_ovf, o_rx_ready, o_acfbsy} !== 5'b00010) begin
      n_err++;
      $display("FAIL back_to_idle: wr/rej/ovf/rdy/bsy got %b expected 00010",
               {o_fifo_wr, o_rej, o_ovf, o_rx_ready, o_acfbsy});
    end
    n_cmp++;
    if ({o_fifo_id, o_fifo_hit, o_fifo_all} !== {m_last_id, m_last_hit, m_last_all}) begin
      n_err++;
      $display("FAIL fifo_hold: got id %h hit %0d all %b expected id %h hit %0d all %b",
               o_fifo_id, o_fifo_hit, o_fifo_all, m_last_id, m_last_hit, m_last_all);
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    step();
    step();
    for (int c = 0; c < 3; c++) begin
      i_rx_valid = 1'b1;
      i_rx_id    = $urandom;
      i_uaf      = 4'($urandom);
      i_cfg_wr   = 1'b1;
      i_cfg_data = $urandom;
      i_fifo_full = 1'($urandom);
      #1;
      n_cmp++;
      if ({o_cfg_err, o_rx_ready, o_fifo_wr, o_fifo_id, o_fifo_hit, o_fifo_all,
           o_acfbsy, o_rej, o_ovf} !== 41'h0) begin
        n_err++;
        $display("FAIL reset_outputs: rdy %b wr %b id %h hit %0d all %b bsy %b rej %b ovf %b err %b expected all 0",
                 o_rx_ready, o_fifo_wr, o_fifo_id, o_fifo_hit, o_fifo_all, o_acfbsy, o_rej, o_ovf, o_cfg_err);
      end
      step();
    end
    i_reset     = 1'b0;
    i_rx_valid  = 1'b0;
    i_cfg_wr    = 1'b0;
    i_fifo_full = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (o_rx_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ready_after_reset: got %b expected 1", o_rx_ready);
    end
  endtask

  task automatic test_all_pass();
    run_msg(32'h1234_5678, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
  endtask

  task automatic test_slot_hit();
    cfg_write(1'b1, 2'd2, 32'hA000_0000, 4'b0000);
    cfg_write(1'b0, 2'd2, 32'hFFE0_0000, 4'b1011);
    run_msg(32'hA01F_FFFF, 4'b0100, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
    run_msg(32'hB000_0000, 4'b0100, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
  endtask

  task automatic test_priority_ovf();
    cfg_write(1'b1, 2'd1, 32'h0000_0550, 4'b0000);
    cfg_write(1'b0, 2'd1, 32'h0000_0FF0, 4'b0000);
    cfg_write(1'b1, 2'd3, 32'h0000_0555, 4'b0000);
    cfg_write(1'b0, 2'd3, 32'hFFFF_FFFF, 4'b0000);
    run_msg(32'h0000_0555, 4'b1010, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
    // Simultaneous config write to a disabled slot while the FIFO is full.
    run_msg(32'h0000_0555, 4'b1010, 1'b1, 1'b1, 1'b0, 2'd0, 32'hFFFF_FFFF);
  endtask

  task automatic test_cfg_err();
    cfg_write(1'b0, 2'd0, 32'hFFFF_FFFF, 4'b0000);
    cfg_write(1'b1, 2'd0, 32'h0000_0011, 4'b0000);
    cfg_write(1'b1, 2'd0, 32'h0000_0022, 4'b0001);
    step();
    #1;
    n_cmp++;
    if (o_cfg_err !== 1'b0) begin
      n_err++;
      $display("FAIL cfg_err_one_cycle: got %b expected 0", o_cfg_err);
    end
    run_msg(32'h0000_0011, 4'b0001, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);

    i_rx_valid = 1'b1;
    i_rx_id    = 32'hB000_0000;
    i_uaf      = 4'b0100;
    #1;
    step();
    i_rx_valid = 1'b0;
    i_cfg_wr   = 1'b1;
    i_cfg_sel  = 1'b1;
    i_cfg_idx  = 2'd2;
    i_cfg_data = 32'hDEAD_BEEF;
    i_uaf      = 4'b0000;
    step();
    i_cfg_wr = 1'b0;
    #1;
    n_cmp++;
    if (o_cfg_err !== 1'b1) begin
      n_err++;
      $display("FAIL scan_write_err: got %b expected 1", o_cfg_err);
    end
    step();
    #1;
    n_cmp++;
    if ({o_cfg_err, o_rej} !== 2'b00) begin
      n_err++;
      $display("FAIL scan_cycle3: err/rej got %b expected 00", {o_cfg_err, o_rej});
    end
    step();
    #1;
    n_cmp++;
    if ({o_rej, o_fifo_wr} !== 2'b10) begin
      n_err++;
      $display("FAIL scan_reject: rej/wr got %b expected 10", {o_rej, o_fifo_wr});
    end
    step();
    #1;
    n_cmp++;
    if (o_rx_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ready_after_reject: got %b expected 1", o_rx_ready);
    end
    run_msg(32'hA01F_FFFF, 4'b0100, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
  endtask

  task automatic test_reset_mid_scan();
    i_rx_valid = 1'b1;
    i_rx_id    = 32'hA01F_FFFF;
    i_uaf      = 4'b0100;
    #1;
    step();
    i_rx_valid = 1'b0;
    step();
    i_reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_cmp++;
      if ({o_cfg_err, o_rx_ready, o_fifo_wr, o_fifo_id, o_fifo_hit, o_fifo_all,
           o_acfbsy, o_rej, o_ovf} !== 41'h0) begin
        n_err++;
        $display("FAIL reset_abort: cycle %0d rdy %b wr %b id %h hit %0d all %b bsy %b rej %b ovf %b err %b expected all 0",
                 c, o_rx_ready, o_fifo_wr, o_fifo_id, o_fifo_hit, o_fifo_all, o_acfbsy, o_rej, o_ovf, o_cfg_err);
      end
      step();
    end
    i_reset = 1'b0;
    model_reset();
    // Cleared masks make every enabled slot match.
    run_msg(32'hCAFE_0001, 4'b0010, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
  endtask

  task automatic test_back_to_back_random();
    for (int n = 0; n < 60; n++) begin
      int          s;
      logic [31:0] id;
      if ($urandom_range(0, 3) == 0) begin
        cfg_write(1'($urandom), 2'($urandom), $urandom & $urandom, 4'($urandom));
      end else begin
        s  = $urandom_range(0, NAF - 1);
        id = ($urandom_range(0, 2) != 0) ? (m_afir[s] ^ ($urandom & ~m_afmr[s])) : $urandom;
        run_msg(id, 4'($urandom), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) == 0), 1'($urandom), 2'($urandom), $urandom);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_all_pass();
    test_slot_hit();
    test_priority_ovf();
    test_cfg_err();
    test_reset_mid_scan();
    test_back_to_back_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/can_acf_ctrl.md
CAN_ACF_CTRL -- requirements
Module: can_acf_ctrl

Interface
REQ-001 Parameter NUM_AF, default 4, number of ID/mask filter slots (power of 2, 1..8).
REQ-002 Parameter ID_W, default 32, width of the received ID word and of each filter register.
REQ-003 i_sys_clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 i_reset  in  1  reset, synchronous, active-high.
REQ-005 i_uaf  in  NUM_AF  per-slot use-acceptance-filter enable.
REQ-006 i_cfg_wr  in  1  single-cycle filter-register write strobe.
REQ-007 i_cfg_sel  in  1  write target: 0 = mask register, 1 = ID register.
REQ-008 i_cfg_idx  in  clog2(NUM_AF)  target slot.
REQ-009 i_cfg_data  in  ID_W  write data.
REQ-010 o_cfg_err  out  1  one-cycle pulse when a write is rejected.
REQ-011 i_rx_valid  in  1  received ID word valid.
REQ-012 i_rx_id  in  ID_W  received ID word.
REQ-013 o_rx_ready  out  1  controller can accept an ID word.
REQ-014 o_fifo_wr  out  1  one-cycle RX FIFO write strobe.
REQ-015 o_fifo_id  out  ID_W  accepted ID word, valid with o_fifo_wr.
REQ-016 o_fifo_hit  out  clog2(NUM_AF)  index of the matching slot, valid with o_fifo_wr.
REQ-017 o_fifo_all  out  1  accepted because no slot was enabled, valid with o_fifo_wr.
REQ-018 i_fifo_full  in  1  RX FIFO full.
REQ-019 o_acfbsy  out  1  filter busy (SCAN or WRITE).
REQ-020 o_rej  out  1  one-cycle pulse, message rejected by all enabled slots.
REQ-021 o_ovf  out  1  one-cycle pulse, accepted message dropped because the FIFO was full.

Function
REQ-022 Per-slot storage shall be afmr[k] and afir[k], each ID_W bits; slot k matches when ((id ^ afir[k]) & afmr[k]) == 0.
REQ-023 The FSM shall have three states: IDLE, SCAN and WRITE. o_rx_ready shall be 1 only in IDLE with i_reset low.
REQ-024 IDLE: when i_rx_valid and o_rx_ready are both high, the controller shall latch i_rx_id and snapshot i_uaf. If the snapshot is all zero, it shall go to WRITE with all=1; otherwise it shall go to SCAN with idx=0.
REQ-025 SCAN: slot idx shall be evaluated each cycle, and disabled slots shall still consume one cycle.
- On the first enabled match, go to WRITE with hit=idx.
- Otherwise, if idx==NUM_AF-1, pulse o_rej and go to IDLE.
- Otherwise, increment idx.
REQ-026 The lowest-index matching enabled slot shall win; idx shall not wrap.
REQ-027 WRITE shall last exactly one cycle and then return to IDLE.
- If i_fifo_full is 0, o_fifo_wr=1 with id, hit and all registered.
- If i_fifo_full is 1, o_fifo_wr=0 and o_ovf=1.
- There is no stall: CAN cannot back-pressure.
REQ-028 Latency from the accept cycle:
- o_fifo_wr in the next cycle (all=1 path).
- o_fifo_wr in cycle k+2 for a hit in slot k.
- o_rej in cycle NUM_AF.
REQ-029 A config write shall be applied the next cycle only if i_uaf[i_cfg_idx]==0 and the state is IDLE; otherwise it shall be discarded and o_cfg_err pulsed the next cycle.
REQ-030 A config write and an rx accept in the same IDLE cycle shall both take effect; the scan shall use the updated registers.
REQ-031 Changes to i_uaf during SCAN/WRITE shall not affect the current message (snapshot).
REQ-032 o_fifo_hit shall be 0 when o_fifo_all=1; o_fifo_id, o_fifo_hit and o_fifo_all shall hold their last values when o_fifo_wr=0.
REQ-033 o_acfbsy shall be a registered decode of state != IDLE.

Reset
REQ-034 While i_reset is high: state=IDLE, idx=0, all afmr and afir =0, and every output =0, including o_rx_ready.
REQ-035 Reset asserted mid-SCAN or mid-WRITE shall abort the message with no o_fifo_wr, o_rej or o_ovf.
REQ-036 The first accept shall be possible in the first cycle after i_reset falls.

Structure
REQ-037 Package can_acf_pkg shall hold the FSM state enum, the default NUM_AF and ID_W values, and the localparam COMPARE = 0.
REQ-038 One sub-module, can_acf_match, shall hold the combinational single-slot compare (id, afir, afmr -> match), instantiated once and driven by the mux at idx.

Verification
REQ-039 Reset, then i_uaf=0, rx id 32'h1234_5678 -> o_fifo_wr next cycle with o_fifo_all=1 and o_fifo_id=32'h1234_5678.
REQ-040 Slot 2: afir=32'hA000_0000, afmr=32'hFFE0_0000, i_uaf=4'b0100, rx id 32'hA01F_FFFF -> o_fifo_wr 4 cycles after accept, o_fifo_hit=2.
REQ-041 Same config, rx id 32'hB000_0000 -> o_rej in cycle 4 and no o_fifo_wr; o_rx_ready back to 1 in cycle 5.
REQ-042 Slots 1 and 3 both enabled and matching -> o_fifo_hit=1; the same stimulus with i_fifo_full=1 -> o_ovf pulse, no o_fifo_wr.
REQ-043 Config write to slot 0 with i_uaf[0]=1 -> o_cfg_err and afir[0] unchanged; a write during SCAN -> o_cfg_err.
REQ-044 i_reset asserted in SCAN cycle 2 -> no o_fifo_wr or o_rej; all outputs 0; accept possible the cycle after release.
